// File: rtl/uart_frame_scheduler.sv
// Shares one uart_transmit between pitch and decimated-sample requesters as 4-byte checksummed frames.
// Request->grant 2 cycles, grant->first trigger 1 cycle; stalls on tx_busy_in, and a new request overwrites a full slot and counts a drop.
module uart_frame_scheduler #(
    parameter int unsigned TAU_WIDTH    = 11,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned DECIMATE     = 256,
    parameter logic [7:0]  SYNC_TAU     = 8'hA5,
    parameter logic [7:0]  SYNC_SMP     = 8'h5A
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [TAU_WIDTH-1:0]    taumin_in,
    input  logic                    taumin_valid_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    input  logic                    sample_en_in,
    input  logic                    tx_busy_in,
    output logic [7:0]              tx_byte_out,
    output logic                    tx_trigger_out,
    output logic [7:0]              drops_out,
    output logic                    active_out
);
    localparam int unsigned      CNT_W    = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATE - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACCEPT, WAIT_DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [3:0][7:0]         frame_q, frame_d;
    logic [7:0]              tx_byte_q, tx_byte_d;
    logic                    tx_trig_q, tx_trig_d;
    logic [TAU_WIDTH-1:0]    tau_q, tau_d;
    logic                    tau_full_q, tau_full_d;
    logic [SAMPLE_WIDTH-1:0] smp_q, smp_d;
    logic                    smp_full_q, smp_full_d;
    logic [CNT_W-1:0]        dcnt_q, dcnt_d;
    logic                    last_smp_q, last_smp_d;
    logic [7:0]              drops_q, drops_d;

    logic       grant_tau, grant_smp, smp_hit, tau_drop, smp_drop;
    logic [15:0] tau_ext;
    logic [7:0] sync_sel, hi_sel, lo_sel, sum_sel;
    logic [8:0] drops_sum;

    // Round-robin only matters when both slots are full: favour the source not served last.
    assign grant_tau = (state_q == IDLE) && tau_full_q && (!smp_full_q || last_smp_q);
    assign grant_smp = (state_q == IDLE) && smp_full_q && (!tau_full_q || !last_smp_q);
    assign smp_hit   = sample_valid_in && sample_en_in && (dcnt_q == CNT_LAST);
    assign tau_drop  = taumin_valid_in && tau_full_q && !grant_tau;
    assign smp_drop  = smp_hit && smp_full_q && !grant_smp;

    assign tau_ext   = 16'(tau_q);
    assign sync_sel  = grant_tau ? SYNC_TAU      : SYNC_SMP;
    assign hi_sel    = grant_tau ? tau_ext[15:8] : smp_q[15:8];
    assign lo_sel    = grant_tau ? tau_ext[7:0]  : smp_q[7:0];
    assign sum_sel   = sync_sel + hi_sel + lo_sel;
    assign drops_sum = {1'b0, drops_q} + {8'd0, tau_drop} + {8'd0, smp_drop};

    always_comb begin
        tau_d      = tau_q;
        tau_full_d = tau_full_q;
        smp_d      = smp_q;
        smp_full_d = smp_full_q;
        dcnt_d     = dcnt_q;
        drops_d    = drops_sum[8] ? 8'hFF : drops_sum[7:0];

        // Clear first so a same-cycle load leaves the slot full with the new value.
        if (grant_tau) tau_full_d = 1'b0;
        if (taumin_valid_in) begin
            tau_d      = taumin_in;
            tau_full_d = 1'b1;
        end

        if (grant_smp) smp_full_d = 1'b0;
        if (smp_hit) begin
            smp_d      = sample_in;
            smp_full_d = 1'b1;
        end

        if (!sample_en_in) begin
            dcnt_d = '0;
        end else if (sample_valid_in) begin
            dcnt_d = (dcnt_q == CNT_LAST) ? '0 : dcnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        tx_byte_d  = tx_byte_q;
        tx_trig_d  = 1'b0;
        last_smp_d = last_smp_q;

        case (state_q)
            IDLE: begin
                if (grant_tau || grant_smp) begin
                    frame_d[0] = sync_sel;
                    frame_d[1] = hi_sel;
                    frame_d[2] = lo_sel;
                    frame_d[3] = 8'd0 - sum_sel;
                    last_smp_d = grant_smp;
                    idx_d      = 2'd0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (!tx_busy_in) begin
                    tx_byte_d = frame_q[idx_q];
                    tx_trig_d = 1'b1;
                    state_d   = WAIT_ACCEPT;
                end
            end
            WAIT_ACCEPT: begin
                if (tx_busy_in) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy_in) begin
                    if (idx_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            frame_q    <= '0;
            tx_byte_q  <= 8'd0;
            tx_trig_q  <= 1'b0;
            tau_q      <= '0;
            tau_full_q <= 1'b0;
            smp_q      <= '0;
            smp_full_q <= 1'b0;
            dcnt_q     <= '0;
            last_smp_q <= 1'b1;
            drops_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            tx_byte_q  <= tx_byte_d;
            tx_trig_q  <= tx_trig_d;
            tau_q      <= tau_d;
            tau_full_q <= tau_full_d;
            smp_q      <= smp_d;
            smp_full_q <= smp_full_d;
            dcnt_q     <= dcnt_d;
            last_smp_q <= last_smp_d;
            drops_q    <= drops_d;
        end
    end

    assign tx_byte_out    = tx_byte_q;
    assign tx_trigger_out = tx_trig_q;
    assign drops_out      = drops_q;
    assign active_out     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Randomised bench for uart_frame_scheduler: a UART busy model, a frame-level scoreboard and a monitor.
// Expected frames are queued in grant order from a request-level model; the monitor compares completed frames.
module tb_uart_frame_scheduler;
    localparam int DEC = 4;

    logic        clk;
    logic        rst_n;
    logic [10:0] taumin;
    logic        tau_vld;
    logic [15:0] smp;
    logic        smp_vld;
    logic        smp_en;
    logic        tx_busy;
    logic [7:0]  tx_byte;
    logic        tx_trig;
    logic [7:0]  drops;
    logic        active;
    logic        uart_busy;
    logic        force_busy;

    int          checks;
    int          errors;
    int          busy_len;
    int          trig_cnt;
    int          mon_n;
    logic        prev_trig;
    logic [7:0]  last_byte;
    logic [31:0] got;
    logic [31:0] exp_q[$];

    int          dcnt;
    bit          last_smp;
    int          drops_exp;

    assign tx_busy = uart_busy | force_busy;

    uart_frame_scheduler #(
        .TAU_WIDTH(11), .SAMPLE_WIDTH(16), .DECIMATE(DEC), .SYNC_TAU(8'hA5), .SYNC_SMP(8'h5A)
    ) dut (
        .clk_in(clk), .rst_in(rst_n),
        .taumin_in(taumin), .taumin_valid_in(tau_vld),
        .sample_in(smp), .sample_valid_in(smp_vld), .sample_en_in(smp_en),
        .tx_busy_in(tx_busy), .tx_byte_out(tx_byte), .tx_trigger_out(tx_trig),
        .drops_out(drops), .active_out(active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_frame(input int s, input int h, input int l);
        int c;
        c = (256 - ((s + h + l) % 256)) % 256;
        return {8'(s), 8'(h), 8'(l), 8'(c)};
    endfunction

    task automatic push_tau(input int v);
        exp_q.push_back(mk_frame(8'hA5, v / 256, v % 256));
        last_smp = 1'b0;
    endtask

    task automatic push_smp(input int v);
        exp_q.push_back(mk_frame(8'h5A, v / 256, v % 256));
        last_smp = 1'b1;
    endtask

    task automatic push_both(input int tv, input int sv);
        if (last_smp) begin
            push_tau(tv);
            push_smp(sv);
        end else begin
            push_smp(sv);
            push_tau(tv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic tau_strobe(input int v);
        taumin = 11'(v);
        tau_vld = 1'b1;
        @(negedge clk);
        tau_vld = 1'b0;
    endtask

    task automatic smp_strobe(input logic [15:0] v, output bit wrapped);
        smp = v;
        smp_vld = 1'b1;
        @(negedge clk);
        smp_vld = 1'b0;
        wrapped = 1'b0;
        if (smp_en) begin
            dcnt++;
            if (dcnt == DEC) begin
                dcnt = 0;
                wrapped = 1'b1;
            end
        end
    endtask

    task automatic prime();
        bit w;
        while (dcnt != DEC - 1) smp_strobe(16'($urandom), w);
    endtask

    task automatic both_strobe(input int tv, input logic [15:0] sv);
        taumin = 11'(tv);
        tau_vld = 1'b1;
        smp = sv;
        smp_vld = 1'b1;
        @(negedge clk);
        tau_vld = 1'b0;
        smp_vld = 1'b0;
        dcnt = (dcnt + 1) % DEC;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || active || mon_n != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: timeout with %0d frames outstanding", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_active(input int budget);
        int n;
        n = 0;
        while (!active && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_active: active_out never rose");
        end
    endtask

    // UART model: accepts a trigger, raises busy after 0-2 cycles and holds it for busy_len cycles.
    initial begin
        uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_trig) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                uart_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                uart_busy = 1'b0;
            end
        end
    end

    // Monitor: assembles bytes into frames and checks pulse width and byte stability.
    initial begin
        mon_n = 0;
        trig_cnt = 0;
        prev_trig = 1'b0;
        last_byte = 8'd0;
        got = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_n = 0;
                prev_trig = 1'b0;
                last_byte = 8'd0;
            end else begin
                if (tx_trig) begin
                    trig_cnt++;
                    check("trig_pulse_width", {31'd0, prev_trig}, 32'd0);
                    got = {got[23:0], tx_byte};
                    last_byte = tx_byte;
                    mon_n++;
                    if (mon_n == 4) begin
                        mon_n = 0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame: got %h but no frame was expected", got);
                        end else begin
                            check("frame", got, exp_q.pop_front());
                        end
                    end
                end else begin
                    check("byte_hold", {24'd0, tx_byte}, {24'd0, last_byte});
                end
                prev_trig = tx_trig;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, tv, a, lastv, t0, n, k;
        logic [15:0] sv;
        bit w;

        checks = 0; errors = 0;
        rst_n = 1'b0; taumin = '0; tau_vld = 1'b0; smp = '0; smp_vld = 1'b0; smp_en = 1'b0;
        force_busy = 1'b0; busy_len = 40;
        dcnt = 0; last_smp = 1'b1; drops_exp = 0;
        repeat (3) @(negedge clk);
        check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        check("rst_trigger", {31'd0, tx_trig}, 32'd0);
        check("rst_drops", {24'd0, drops}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single pitch frame with request-to-trigger latency.
        t0 = trig_cnt;
        push_tau(1234);
        tau_strobe(1234);
        check("lat_active_c1", {31'd0, active}, 32'd0);
        tick();
        check("lat_active_c2", {31'd0, active}, 32'd1);
        check("lat_trig_c2", {31'd0, tx_trig}, 32'd0);
        tick();
        check("lat_trig_c3", {31'd0, tx_trig}, 32'd1);
        check("lat_byte0_c3", {24'd0, tx_byte}, 32'hA5);
        wait_idle(2000);
        check("single_trig_count", trig_cnt - t0, 32'd4);
        check("single_drops", {24'd0, drops}, drops_exp);

        // Sample frames: one per DEC enabled samples.
        busy_len = 8;
        smp_en = 1'b1;
        for (int i = 0; i < 3; i++) smp_strobe(16'($urandom), w);
        push_smp(16'h1234);
        smp_strobe(16'h1234, w);
        wait_idle(2000);
        for (int i = 0; i < 2 * DEC; i++) begin
            sv = 16'($urandom);
            smp_strobe(sv, w);
            if (w) push_smp(sv);
        end
        wait_idle(3000);

        smp_en = 1'b0;
        dcnt = 0;
        t0 = trig_cnt;
        for (int i = 0; i < 3 * DEC; i++) smp_strobe(16'($urandom), w);
        repeat (60) tick();
        check("no_frames_en0", trig_cnt - t0, 32'd0);

        // A sample captured just before disabling is still sent.
        smp_en = 1'b1;
        busy_len = 10;
        v = int'($urandom % 2048);
        push_tau(v);
        tau_strobe(v);
        wait_active(50);
        prime();
        sv = 16'($urandom);
        smp_strobe(sv, w);
        push_smp(sv);
        smp_en = 1'b0;
        dcnt = 0;
        wait_idle(3000);

        // Randomised mix of request patterns.
        smp_en = 1'b1;
        for (int it = 0; it < 24; it++) begin
            busy_len = 1 + int'($urandom % 6);
            k = int'($urandom % 4);
            case (k)
                0: begin
                    v = int'($urandom % 2048);
                    push_tau(v);
                    tau_strobe(v);
                end
                1: begin
                    do begin
                        sv = 16'($urandom);
                        repeat ($urandom % 3) tick();
                        smp_strobe(sv, w);
                    end while (!w);
                    push_smp(sv);
                end
                2: begin
                    prime();
                    tv = int'($urandom % 2048);
                    sv = 16'($urandom);
                    push_both(tv, sv);
                    both_strobe(tv, sv);
                end
                default: begin
                    v = int'($urandom % 2048);
                    push_tau(v);
                    tau_strobe(v);
                    wait_active(50);
                    v = int'($urandom % 2048);
                    push_tau(v);
                    tau_strobe(v);
                end
            endcase
            wait_idle(3000);
        end
        check("random_drops", {24'd0, drops}, drops_exp);

        // Round-robin: simultaneous requests, then requests behind an in-flight frame.
        busy_len = 6;
        for (int r = 0; r < 2; r++) begin
            prime();
            tv = int'($urandom % 2048);
            sv = 16'($urandom);
            push_both(tv, sv);
            both_strobe(tv, sv);
            wait_idle(3000);
        end
        v = int'($urandom % 2048);
        push_tau(v);
        tau_strobe(v);
        wait_active(50);
        prime();
        tv = int'($urandom % 2048);
        sv = 16'($urandom);
        push_both(tv, sv);
        both_strobe(tv, sv);
        wait_idle(3000);
        prime();
        sv = 16'($urandom);
        smp_strobe(sv, w);
        push_smp(sv);
        wait_active(50);
        prime();
        tv = int'($urandom % 2048);
        sv = 16'($urandom);
        push_both(tv, sv);
        both_strobe(tv, sv);
        wait_idle(3000);

        // Load on the grant cycle refills the slot without a drop.
        a = int'($urandom % 2048);
        v = int'($urandom % 2048);
        push_tau(a);
        push_tau(v);
        tau_strobe(a);
        tau_strobe(v);
        check("load_wins_drops", {24'd0, drops}, drops_exp);
        wait_idle(3000);

        // Overwrites behind an in-flight frame.
        busy_len = 20;
        v = int'($urandom % 2048);
        push_tau(v);
        tau_strobe(v);
        wait_active(50);
        tau_strobe(10);
        tick();
        tau_strobe(20);
        tick();
        tau_strobe(30);
        drops_exp += 2;
        push_tau(30);
        check("overwrite_drops", {24'd0, drops}, drops_exp);
        wait_idle(3000);
        check("overwrite_drops_after", {24'd0, drops}, drops_exp);

        // Busy held at grant, saturating drop counter, trigger one cycle after release.
        busy_len = 5;
        force_busy = 1'b1;
        v = int'($urandom % 2048);
        push_tau(v);
        tau_strobe(v);
        wait_active(50);
        t0 = trig_cnt;
        lastv = 0;
        for (int i = 0; i < 301; i++) begin
            lastv = int'($urandom % 2048);
            tau_strobe(lastv);
        end
        drops_exp = (drops_exp + 300 > 255) ? 255 : drops_exp + 300;
        check("drops_saturate", {24'd0, drops}, drops_exp);
        check("no_trig_while_busy", trig_cnt - t0, 32'd0);
        force_busy = 1'b0;
        check("trig_before_release", {31'd0, tx_trig}, 32'd0);
        tick();
        check("trig_after_release", {31'd0, tx_trig}, 32'd1);
        check("byte_after_release", {24'd0, tx_byte}, 32'hA5);
        push_tau(lastv);
        wait_idle(3000);
        check("drops_hold_255", {24'd0, drops}, drops_exp);

        // Asynchronous reset while byte2 is in flight.
        busy_len = 10;
        v = int'($urandom % 2048);
        push_tau(v);
        tau_strobe(v);
        n = 0;
        while (mon_n != 3 && n < 500) begin
            tick();
            n++;
        end
        check("reached_byte2", mon_n, 32'd3);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx_byte", {24'd0, tx_byte}, 32'd0);
        check("arst_trigger", {31'd0, tx_trig}, 32'd0);
        check("arst_drops", {24'd0, drops}, 32'd0);
        check("arst_active", {31'd0, active}, 32'd0);
        exp_q.delete();
        last_smp = 1'b1;
        dcnt = 0;
        drops_exp = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        v = int'($urandom % 2048);
        push_tau(v);
        tau_strobe(v);
        wait_idle(3000);
        check("post_reset_drops", {24'd0, drops}, drops_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
